cpu_issue_arbiter: RTL and testbench

- Shares the single-issue `cpu` instruction port between two instruction requesters, e.g. two test streams or a loader plus a debug port.
- Round-robin arbitration; the winning instruction drives the CPU `Instr` input.
- Each `Result` is routed back to the requester that issued the instruction.
- When no request is granted, a NOP is issued.

---
 rtl/cpu_issue_arbiter_pkg.sv | 20 ++
 rtl/cpu_issue_arbiter_rr.sv | 24 ++
 rtl/cpu_issue_arbiter.sv | 115 +++++++++++
 tb/tb_cpu_issue_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_issue_arbiter_pkg.sv
// Shared types and constants for the CPU instruction-port arbiter.
package cpu_issue_arbiter_pkg;

    // Identifies one of the two instruction requesters.
    typedef logic req_id_t;

    // One entry of the in-flight tag pipe: whether a real instruction
    // occupies this slot and which requester issued it.
    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;

    // addi x0,x0,0 -- issued whenever nothing is granted.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Deepest CPU result latency the tag pipe is meant to cover.
    localparam int unsigned MAX_RESULT_LAT = 7;

endpackage

// File: rtl/cpu_issue_arbiter_rr.sv
// Two-way round-robin grant logic: purely combinational, one-hot grant.
module rr_arbiter2
    import cpu_issue_arbiter_pkg::*;
(
    input  logic [1:0] valid,
    input  req_id_t    last_grant,
    input  logic       hold,
    output logic [1:0] grant
);

    // Grant a lone requester outright; on contention favour the one not served last.
    always_comb begin
        grant = 2'b00;
        if (!hold) begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = (last_grant == 1'b1) ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/cpu_issue_arbiter.sv
// Shares the single-issue CPU instruction port between two requesters,
// tracks which requester owns each in-flight instruction and steers the
// CPU result back to it a fixed number of cycles later.
module cpu_issue_arbiter
    import cpu_issue_arbiter_pkg::*;
#(
    parameter int unsigned RESULT_LAT = 1,
    parameter logic [31:0] NOP_INSTR  = cpu_issue_arbiter_pkg::NOP_INSTR,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             req0_valid,
    input  logic [31:0]      req0_instr,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [31:0]      req1_instr,
    output logic             req1_ready,
    output logic [31:0]      cpu_instr,
    input  logic [31:0]      cpu_result,
    output logic             rsp0_valid,
    output logic [31:0]      rsp0_data,
    output logic             rsp1_valid,
    output logic [31:0]      rsp1_data,
    output logic [CNT_W-1:0] issue_cnt0,
    output logic [CNT_W-1:0] issue_cnt1
);

    logic [1:0]         grant;
    logic               grant_any;
    req_id_t            grant_id;
    req_id_t            last_grant;
    tag_t [RESULT_LAT:0] tag_pipe;
    tag_t               final_tag;

    // Reset also blocks grants so no requester believes a transfer
    // happened in a cycle whose instruction would be thrown away.
    rr_arbiter2 u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .hold       (hold | rst),
        .grant      (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign grant_any  = |grant;
    assign grant_id   = grant[1];
    assign final_tag  = tag_pipe[RESULT_LAT];

    // Drive the CPU with the granted instruction, or a NOP when idle/held.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_instr  <= NOP_INSTR;
            last_grant <= 1'b1;
        end else if (grant_any) begin
            cpu_instr  <= grant_id ? req1_instr : req0_instr;
            last_grant <= grant_id;
        end else begin
            cpu_instr  <= NOP_INSTR;
        end
    end

    // Tag pipe: stage 0 mirrors cpu_instr, last stage lines up with its result.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_pipe <= '0;
        end else begin
            tag_pipe[0].valid <= grant_any;
            tag_pipe[0].id    <= grant_id;
            for (int i = 1; i <= int'(RESULT_LAT); i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    // Capture the CPU result for the owning requester as a one-cycle pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp0_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp1_valid <= 1'b0;
            rsp1_data  <= '0;
        end else begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            if (final_tag.valid) begin
                if (final_tag.id == 1'b1) begin
                    rsp1_valid <= 1'b1;
                    rsp1_data  <= cpu_result;
                end else begin
                    rsp0_valid <= 1'b1;
                    rsp0_data  <= cpu_result;
                end
            end
        end
    end

    // Per-requester grant counters that stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt0 <= '0;
            issue_cnt1 <= '0;
        end else begin
            if (grant[0] && (issue_cnt0 != '1)) begin
                issue_cnt0 <= issue_cnt0 + CNT_W'(1);
            end
            if (grant[1] && (issue_cnt1 != '1)) begin
                issue_cnt1 <= issue_cnt1 + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cpu_issue_arbiter.sv
// Self-checking bench for cpu_issue_arbiter: a per-cycle vector table plus
// hand-written reset-in-flight and counter-saturation sequences.
module tb_cpu_issue_arbiter;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic        hold;
        logic        v0;
        logic [31:0] i0;
        logic        v1;
        logic [31:0] i1;
        logic [31:0] res;
        logic        r0;
        logic        r1;
        logic [31:0] instr;
        logic        rv0;
        logic [31:0] rd0;
        logic        rv1;
        logic [31:0] rd1;
        logic [15:0] c0;
        logic [15:0] c1;
    } vec_t;

    localparam int NVEC = 22;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold;
    logic        req0_valid;
    logic [31:0] req0_instr;
    logic        req0_ready;
    logic        req1_valid;
    logic [31:0] req1_instr;
    logic        req1_ready;
    logic [31:0] cpu_instr;
    logic [31:0] cpu_result;
    logic        rsp0_valid;
    logic [31:0] rsp0_data;
    logic        rsp1_valid;
    logic [31:0] rsp1_data;
    logic [15:0] issue_cnt0;
    logic [15:0] issue_cnt1;

    logic        sat_req0_valid;
    logic        sat_req0_ready;
    logic        sat_req1_ready;
    logic [31:0] sat_cpu_instr;
    logic        sat_rsp0_valid;
    logic [31:0] sat_rsp0_data;
    logic        sat_rsp1_valid;
    logic [31:0] sat_rsp1_data;
    logic [1:0]  sat_cnt0;
    logic [1:0]  sat_cnt1;

    int   checks   = 0;
    int   failures = 0;
    vec_t vecs [NVEC];

    always #5 clk = ~clk;

    cpu_issue_arbiter #(.RESULT_LAT(1), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .hold       (hold),
        .req0_valid (req0_valid),
        .req0_instr (req0_instr),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_instr (req1_instr),
        .req1_ready (req1_ready),
        .cpu_instr  (cpu_instr),
        .cpu_result (cpu_result),
        .rsp0_valid (rsp0_valid),
        .rsp0_data  (rsp0_data),
        .rsp1_valid (rsp1_valid),
        .rsp1_data  (rsp1_data),
        .issue_cnt0 (issue_cnt0),
        .issue_cnt1 (issue_cnt1)
    );

    cpu_issue_arbiter #(.RESULT_LAT(1), .CNT_W(2)) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .hold       (1'b0),
        .req0_valid (sat_req0_valid),
        .req0_instr (32'h0050_0093),
        .req0_ready (sat_req0_ready),
        .req1_valid (1'b0),
        .req1_instr (32'h0000_0000),
        .req1_ready (sat_req1_ready),
        .cpu_instr  (sat_cpu_instr),
        .cpu_result (32'h0000_0000),
        .rsp0_valid (sat_rsp0_valid),
        .rsp0_data  (sat_rsp0_data),
        .rsp1_valid (sat_rsp1_valid),
        .rsp1_data  (sat_rsp1_data),
        .issue_cnt0 (sat_cnt0),
        .issue_cnt1 (sat_cnt1)
    );

    function automatic vec_t mkRow(
        input logic hold_i, input logic v0, input logic [31:0] i0,
        input logic v1, input logic [31:0] i1, input logic [31:0] res,
        input logic r0, input logic r1, input logic [31:0] instr,
        input logic rv0, input logic [31:0] rd0,
        input logic rv1, input logic [31:0] rd1,
        input logic [15:0] c0, input logic [15:0] c1);
        vec_t v;
        v.hold = hold_i; v.v0 = v0; v.i0 = i0; v.v1 = v1; v.i1 = i1; v.res = res;
        v.r0 = r0; v.r1 = r1; v.instr = instr;
        v.rv0 = rv0; v.rd0 = rd0; v.rv1 = rv1; v.rd1 = rd1; v.c0 = c0; v.c1 = c1;
        return v;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        hold       = v.hold;
        req0_valid = v.v0;
        req0_instr = v.i0;
        req1_valid = v.v1;
        req1_instr = v.i1;
        cpu_result = v.res;
    endtask

    task automatic checkOutput(input int k, input vec_t v);
        checkVal($sformatf("row%0d.req0_ready", k), 32'(req0_ready), 32'(v.r0));
        checkVal($sformatf("row%0d.req1_ready", k), 32'(req1_ready), 32'(v.r1));
        checkVal($sformatf("row%0d.cpu_instr", k), cpu_instr, v.instr);
        checkVal($sformatf("row%0d.rsp0_valid", k), 32'(rsp0_valid), 32'(v.rv0));
        checkVal($sformatf("row%0d.rsp0_data", k), rsp0_data, v.rd0);
        checkVal($sformatf("row%0d.rsp1_valid", k), 32'(rsp1_valid), 32'(v.rv1));
        checkVal($sformatf("row%0d.rsp1_data", k), rsp1_data, v.rd1);
        checkVal($sformatf("row%0d.issue_cnt0", k), 32'(issue_cnt0), 32'(v.c0));
        checkVal($sformatf("row%0d.issue_cnt1", k), 32'(issue_cnt1), 32'(v.c1));
    endtask

    task automatic driveIdle();
        hold       = 1'b0;
        req0_valid = 1'b0;
        req0_instr = 32'h0;
        req1_valid = 1'b0;
        req1_instr = 32'h0;
        cpu_result = 32'hDEAD_0000;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = mkRow(0,0,32'h0,0,32'h0,32'hC000_0000, 0,0,NOP, 0,32'h0,0,32'h0, 0,0);
        vecs[1]  = mkRow(0,0,32'h0,0,32'h0,32'hC000_0001, 0,0,NOP, 0,32'h0,0,32'h0, 0,0);
        vecs[2]  = mkRow(0,1,32'h0050_0093,0,32'h0,32'hC000_0002, 1,0,NOP, 0,32'h0,0,32'h0, 0,0);
        vecs[3]  = mkRow(0,0,32'h0,0,32'h0,32'hC000_0003, 0,0,32'h0050_0093, 0,32'h0,0,32'h0, 1,0);
        vecs[4]  = mkRow(0,0,32'h0,0,32'h0,32'hC000_0004, 0,0,NOP, 0,32'h0,0,32'h0, 1,0);
        vecs[5]  = mkRow(0,0,32'h0,0,32'h0,32'hC000_0005, 0,0,NOP, 1,32'hC000_0004,0,32'h0, 1,0);
        vecs[6]  = mkRow(0,1,32'h0010_0113,1,32'h0040_0193,32'hC000_0006, 0,1,NOP, 0,32'hC000_0004,0,32'h0, 1,0);
        vecs[7]  = mkRow(0,1,32'h0010_0113,1,32'h0050_0193,32'hC000_0007, 1,0,32'h0040_0193, 0,32'hC000_0004,0,32'h0, 1,1);
        vecs[8]  = mkRow(0,1,32'h0020_0113,1,32'h0050_0193,32'hC000_0008, 0,1,32'h0010_0113, 0,32'hC000_0004,0,32'h0, 2,1);
        vecs[9]  = mkRow(0,1,32'h0020_0113,1,32'h0060_0193,32'hC000_0009, 1,0,32'h0050_0193, 0,32'hC000_0004,1,32'hC000_0008, 2,2);
        vecs[10] = mkRow(0,1,32'h0030_0113,1,32'h0060_0193,32'hC000_000A, 0,1,32'h0020_0113, 1,32'hC000_0009,0,32'hC000_0008, 3,2);
        vecs[11] = mkRow(0,1,32'h0030_0113,1,32'h0070_0193,32'hC000_000B, 1,0,32'h0060_0193, 0,32'hC000_0009,1,32'hC000_000A, 3,3);
        vecs[12] = mkRow(0,0,32'h0,1,32'h0070_0193,32'hC000_000C, 0,1,32'h0030_0113, 1,32'hC000_000B,0,32'hC000_000A, 4,3);
        vecs[13] = mkRow(1,1,32'h0080_0113,1,32'h0090_0193,32'hC000_000D, 0,0,32'h0070_0193, 0,32'hC000_000B,1,32'hC000_000C, 4,4);
        vecs[14] = mkRow(1,1,32'h0080_0113,1,32'h0090_0193,32'hC000_000E, 0,0,NOP, 1,32'hC000_000D,0,32'hC000_000C, 4,4);
        vecs[15] = mkRow(1,1,32'h0080_0113,1,32'h0090_0193,32'hC000_000F, 0,0,NOP, 0,32'hC000_000D,1,32'hC000_000E, 4,4);
        vecs[16] = mkRow(0,1,32'h0080_0113,1,32'h0090_0193,32'hC000_0010, 1,0,NOP, 0,32'hC000_000D,0,32'hC000_000E, 4,4);
        vecs[17] = mkRow(0,0,32'h0,1,32'h0090_0193,32'hC000_0011, 0,1,32'h0080_0113, 0,32'hC000_000D,0,32'hC000_000E, 5,4);
        vecs[18] = mkRow(0,0,32'h0,0,32'h0,32'hC000_0012, 0,0,32'h0090_0193, 0,32'hC000_000D,0,32'hC000_000E, 5,5);
        vecs[19] = mkRow(0,0,32'h0,0,32'h0,32'hC000_0013, 0,0,NOP, 1,32'hC000_0012,0,32'hC000_000E, 5,5);
        vecs[20] = mkRow(0,0,32'h0,0,32'h0,32'hC000_0014, 0,0,NOP, 0,32'hC000_0012,1,32'hC000_0013, 5,5);
        vecs[21] = mkRow(0,0,32'h0,0,32'h0,32'hC000_0015, 0,0,NOP, 0,32'hC000_0012,0,32'hC000_0013, 5,5);

        rst            = 1'b1;
        sat_req0_valid = 1'b0;
        driveIdle();
        nextCycle();
        nextCycle();

        checkVal("reset.cpu_instr", cpu_instr, NOP);
        checkVal("reset.rsp0_valid", 32'(rsp0_valid), 32'h0);
        checkVal("reset.rsp1_valid", 32'(rsp1_valid), 32'h0);
        checkVal("reset.rsp0_data", rsp0_data, 32'h0);
        checkVal("reset.issue_cnt0", 32'(issue_cnt0), 32'h0);
        checkVal("reset.issue_cnt1", 32'(issue_cnt1), 32'h0);

        rst = 1'b0;
        for (int k = 0; k < NVEC; k++) begin
            applyStimulus(vecs[k]);
            @(negedge clk);
            checkOutput(k, vecs[k]);
            nextCycle();
        end

        // Reset while a requester-1 instruction is in flight.
        driveIdle();
        req1_valid = 1'b1;
        req1_instr = 32'h00A0_0193;
        @(negedge clk);
        checkVal("midrst.grant_req1", 32'(req1_ready), 32'h1);
        nextCycle();
        req1_valid = 1'b0;
        req0_valid = 1'b1;
        req0_instr = 32'h00B0_0113;
        rst        = 1'b1;
        @(negedge clk);
        checkVal("midrst.instr_before_reset", cpu_instr, 32'h00A0_0193);
        checkVal("midrst.no_grant_in_reset", 32'(req0_ready), 32'h0);
        nextCycle();
        rst        = 1'b0;
        req0_valid = 1'b0;
        @(negedge clk);
        checkVal("midrst.cpu_instr_nop", cpu_instr, NOP);
        checkVal("midrst.issue_cnt1", 32'(issue_cnt1), 32'h0);
        checkVal("midrst.issue_cnt0", 32'(issue_cnt0), 32'h0);
        for (int k = 0; k < 5; k++) begin
            checkVal($sformatf("midrst.rsp1_valid_c%0d", k), 32'(rsp1_valid), 32'h0);
            checkVal($sformatf("midrst.rsp0_valid_c%0d", k), 32'(rsp0_valid), 32'h0);
            nextCycle();
            @(negedge clk);
        end

        // After reset requester 0 must win a contended first cycle.
        req0_valid = 1'b1;
        req0_instr = 32'h00C0_0113;
        req1_valid = 1'b1;
        req1_instr = 32'h00D0_0193;
        #1;
        checkVal("postrst.first_winner_req0", 32'(req0_ready), 32'h1);
        checkVal("postrst.first_loser_req1", 32'(req1_ready), 32'h0);
        nextCycle();
        driveIdle();

        // Narrow counter on the second instance must stick at 3.
        sat_req0_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            nextCycle();
            checkVal($sformatf("sat.issue_cnt0_g%0d", k + 1), 32'(sat_cnt0),
                     (k < 3) ? 32'(k + 1) : 32'h3);
        end
        sat_req0_valid = 1'b0;
        nextCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
